// File: rtl/tcdm_bank_adapter.sv
// -----------------------------------------------------------------------------
// tcdm_bank_adapter
//
// Sits between the root of a round-robin arbitration tree and one TCDM SRAM
// bank. The winning request (payload plus winner index) is held in a
// single-entry register stage that drives the bank port. The winner index then
// travels down a fixed-length pipe that matches the bank read latency. The
// bank response is returned to the originating master as a one-hot valid. The
// read data is broadcast to every master.
//
// Parameters:
//   NumReq      number of masters behind the arbiter (r_valid_o width)
//   DataWidth   opaque request payload width (wen/be/addr/wdata packed upstream)
//   RDataWidth  bank read data width
//   MemLatency  cycles from bank acceptance to valid mem_rdata_i (1..4)
//   IdxWidth    derived winner-index width, do not override
//
// Ports:
//   clk_i        clock, all state on the rising edge
//   rst_i        synchronous active-high reset
//   req_i        arbitrated request from the arbiter tree root
//   gnt_o        grant back to the arbiter tree
//   data_i       arbitrated payload
//   idx_i        index of the winning master
//   mem_req_o    bank request valid
//   mem_data_o   bank payload
//   mem_ready_i  bank accepts this cycle (0 = stall)
//   mem_rdata_i  bank read data, valid MemLatency cycles after acceptance
//   r_valid_o    one-hot response valid per master
//   r_rdata_o    response data, broadcast to all masters
//   busy_o       a request is held or still in flight
// -----------------------------------------------------------------------------
module tcdm_bank_adapter #(
  parameter int unsigned NumReq     = 32,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned RDataWidth = 32,
  parameter int unsigned MemLatency = 1,
  parameter int unsigned IdxWidth   = (NumReq > 32'd1) ? $clog2(NumReq) : 32'd1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [DataWidth-1:0]  data_i,
  input  logic [IdxWidth-1:0]   idx_i,
  output logic                  mem_req_o,
  output logic [DataWidth-1:0]  mem_data_o,
  input  logic                  mem_ready_i,
  input  logic [RDataWidth-1:0] mem_rdata_i,
  output logic [NumReq-1:0]     r_valid_o,
  output logic [RDataWidth-1:0] r_rdata_o,
  output logic                  busy_o
);

  // ---------------------------------------------------------------------------
  // Request stage (single entry)
  // ---------------------------------------------------------------------------
  logic                 vld_q,  vld_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic [IdxWidth-1:0]  idx_q,  idx_d;

  logic load_s;
  logic accept_s;

  // The grant depends only on local state and the bank ready. It never looks
  // at req_i, so no combinational req->gnt loop can form through the tree.
  assign gnt_o    = ~vld_q | mem_ready_i;
  assign load_s   = req_i & gnt_o;
  assign accept_s = vld_q & mem_ready_i;

  // Next-state for the request stage. A load that coincides with an accept
  // replaces the entry in place, which gives one request per cycle.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    idx_d  = idx_q;
    if (load_s) begin
      vld_d  = 1'b1;
      data_d = data_i;
      idx_d  = idx_i;
    end else if (accept_s) begin
      vld_d  = 1'b0;
    end else begin
      // Stalled or idle: payload and index stay stable for the bank.
      vld_d  = vld_q;
    end
  end

  // Request stage state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      idx_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      idx_q  <= idx_d;
    end
  end

  assign mem_req_o  = vld_q;
  assign mem_data_o = data_q;

  // ---------------------------------------------------------------------------
  // Latency pipe: carries {valid, winner index} alongside the bank access.
  // The bank response cannot be back-pressured, so the pipe never stalls.
  // ---------------------------------------------------------------------------
  logic [MemLatency-1:0]               pipe_v_q,   pipe_v_d;
  logic [MemLatency-1:0][IdxWidth-1:0] pipe_idx_q, pipe_idx_d;

  // Shift the pipe by one stage every cycle. Stage 0 takes the accept.
  always_comb begin
    pipe_v_d      = pipe_v_q;
    pipe_idx_d    = pipe_idx_q;
    pipe_v_d[0]   = accept_s;
    pipe_idx_d[0] = idx_q;
    for (int unsigned k = 1; k < MemLatency; k++) begin
      pipe_v_d[k]   = pipe_v_q[k-1];
      pipe_idx_d[k] = pipe_idx_q[k-1];
    end
  end

  // Latency pipe state register. Reset drops every in-flight response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_v_q   <= '0;
      pipe_idx_q <= '0;
    end else begin
      pipe_v_q   <= pipe_v_d;
      pipe_idx_q <= pipe_idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Response routing
  // ---------------------------------------------------------------------------
  logic                last_v_s;
  logic [IdxWidth-1:0] last_idx_s;
  logic [31:0]         last_idx_ext_s;

  assign last_v_s       = pipe_v_q[MemLatency-1];
  assign last_idx_s     = pipe_idx_q[MemLatency-1];
  assign last_idx_ext_s = 32'(last_idx_s);

  // One-hot decode of the winner index. The loop covers only the real
  // masters, so an index at or above NumReq (possible when NumReq is not a
  // power of two) decodes to all-zero.
  always_comb begin
    r_valid_o = '0;
    for (int unsigned m = 0; m < NumReq; m++) begin
      r_valid_o[m] = last_v_s & (last_idx_ext_s == m);
    end
  end

  // Read data is only meaningful together with r_valid_o. It passes straight
  // through because the bank already aligns it with the last pipe stage.
  assign r_rdata_o = mem_rdata_i;

  assign busy_o = vld_q | (|pipe_v_q);

endmodule
